// File: rtl/bn_bias_requant_if.sv
// Streaming handshake bundle for the batchnorm bias/requantise stage:
// a 2*BITS-wide product goes in, a BITS-wide requantised sample comes out.
interface bn_bias_requant_if #(
   parameter int BITS = 17
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [2*BITS-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [BITS-1:0]   out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/bn_bias_requant.sv
// Two-stage batchnorm bias add and requantise: S1 adds the Q(NFRAC) bias to the
// Q(2*NFRAC) product, S2 rounds half-up, saturates, optionally applies ReLU.
module bn_bias_requant #(
   parameter int BITS  = 17,
   parameter int NFRAC = 8,
   parameter int BIAS  = 0,
   parameter int RELU  = 0
) (
   input  logic             clk,
   input  logic             reset,
   bn_bias_requant_if.slave bus,
   output logic [15:0]      sat_count,
   output logic             sat_flag
);
   localparam int SW = 2*BITS + 1;
   localparam logic signed [BITS-1:0] BIAS_B = BITS'(BIAS);
   // Bias moved to the product's 2*NFRAC fractional scale.
   localparam logic signed [SW-1:0] BIAS_SH =
      {{(SW-BITS){BIAS_B[BITS-1]}}, BIAS_B} << NFRAC;
   localparam logic signed [SW:0] RND  = {{(SW+1-NFRAC){1'b0}}, 1'b1, {(NFRAC-1){1'b0}}};
   localparam logic signed [SW:0] MAXV = {{(SW-BITS+2){1'b0}}, {(BITS-1){1'b1}}};
   localparam logic signed [SW:0] MINV = ~MAXV;

   logic                   s1_valid, s2_valid;
   logic                   s1_adv, s2_adv;
   logic signed [SW-1:0]   s1_sum;
   logic signed [SW:0]     r;
   logic                   sat_hi, sat_lo;
   logic signed [BITS-1:0] clip, res, res_q;

   assign s2_adv       = !s2_valid || bus.out_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign bus.in_ready = !reset && s1_adv;
   assign bus.out_valid = s2_valid;
   assign bus.out_data  = res_q;

   always_ff @(posedge clk) begin
      if (reset)
         s1_valid <= 1'b0;
      else if (s1_adv)
         s1_valid <= bus.in_valid;
   end

   always_ff @(posedge clk) begin
      if (s1_adv && bus.in_valid)
         s1_sum <= {{(BITS+1){bus.in_data[2*BITS-1]}}, bus.in_data} + BIAS_SH;
   end

   // One guard bit above the sum so the rounding constant cannot wrap.
   always_comb begin
      r      = $signed({s1_sum[SW-1], s1_sum} + RND) >>> NFRAC;
      sat_hi = r > MAXV;
      sat_lo = r < MINV;
      clip   = r[BITS-1:0];
      if (sat_hi)
         clip = MAXV[BITS-1:0];
      else if (sat_lo)
         clip = MINV[BITS-1:0];
      res = (RELU != 0 && clip[BITS-1]) ? '0 : clip;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid  <= 1'b0;
         res_q     <= '0;
         sat_count <= '0;
         sat_flag  <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            res_q <= res;
            if (sat_hi || sat_lo) begin
               sat_flag <= 1'b1;
               if (sat_count != 16'hFFFF)
                  sat_count <= sat_count + 16'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_bn_bias_requant.sv
// Scoreboard bench: three variants (BIAS=0, BIAS=256, RELU=1) share one stimulus
// stream; expected samples are queued on accept and popped by a negedge monitor.
module tb_bn_bias_requant;
   logic clk, reset;
   logic in_valid, out_ready;
   logic signed [33:0] in_data;
   int cyc;
   int errs, chks;
   bit lat_mode;

   typedef struct {
      int d;
      int acc;
      bit lat;
   } exp_t;

   exp_t q [3][$];

   // BIAS=0 product, expected outputs for u0 (BIAS=0), u1 (BIAS=256), u2 (RELU=1)
   localparam logic signed [33:0] VIN [12] = '{
      34'sd327680, 34'sd128, 34'sd127, -34'sd128, -34'sd129,
      34'sd1073741824, -34'sd1073741824, -34'sd196608,
      34'sd16776960, 34'sd16777088, -34'sd16777216, -34'sd16777345};
   localparam int E0 [12] = '{1280, 1, 0, 0, -1, 65535, -65536, -768,
                              65535, 65535, -65536, -65536};
   localparam int E1 [12] = '{1536, 257, 256, 256, 255, 65535, -65536, -512,
                              65535, 65535, -65280, -65281};
   localparam int E2 [12] = '{1280, 1, 0, 0, 0, 65535, 0, 0,
                              65535, 65535, 0, 0};

   bn_bias_requant_if #(.BITS(17)) bif0 ();
   bn_bias_requant_if #(.BITS(17)) bif1 ();
   bn_bias_requant_if #(.BITS(17)) bif2 ();

   logic [15:0] scv [3];
   logic        sfv [3];
   logic        ov  [3];
   int          od  [3];

   assign bif0.in_valid = in_valid;  assign bif0.in_data = in_data;  assign bif0.out_ready = out_ready;
   assign bif1.in_valid = in_valid;  assign bif1.in_data = in_data;  assign bif1.out_ready = out_ready;
   assign bif2.in_valid = in_valid;  assign bif2.in_data = in_data;  assign bif2.out_ready = out_ready;
   assign ov[0] = bif0.out_valid;  assign od[0] = int'(bif0.out_data);
   assign ov[1] = bif1.out_valid;  assign od[1] = int'(bif1.out_data);
   assign ov[2] = bif2.out_valid;  assign od[2] = int'(bif2.out_data);

   bn_bias_requant #(.BITS(17), .NFRAC(8), .BIAS(0), .RELU(0)) u0 (
      .clk(clk), .reset(reset), .bus(bif0), .sat_count(scv[0]), .sat_flag(sfv[0]));
   bn_bias_requant #(.BITS(17), .NFRAC(8), .BIAS(256), .RELU(0)) u1 (
      .clk(clk), .reset(reset), .bus(bif1), .sat_count(scv[1]), .sat_flag(sfv[1]));
   bn_bias_requant #(.BITS(17), .NFRAC(8), .BIAS(0), .RELU(1)) u2 (
      .clk(clk), .reset(reset), .bus(bif2), .sat_count(scv[2]), .sat_flag(sfv[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      chks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int k);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = VIN[k];
      while (!bif0.in_ready && t < 50) begin
         tick();
         t++;
      end
      chk($sformatf("accept_vec%0d", k), int'(bif0.in_ready), 1);
      if (bif0.in_ready) begin
         q[0].push_back('{d: E0[k], acc: cyc, lat: lat_mode});
         q[1].push_back('{d: E1[k], acc: cyc, lat: lat_mode});
         q[2].push_back('{d: E2[k], acc: cyc, lat: lat_mode});
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic chk_sat(input string nm, input int cnt, input int flg);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_count_u%0d", nm, i), int'(scv[i]), cnt);
         chk($sformatf("%s_flag_u%0d", nm, i), int'(sfv[i]), flg);
      end
   endtask

   task automatic chk_empty(input string nm);
      for (int i = 0; i < 3; i++)
         chk($sformatf("%s_pending_u%0d", nm, i), q[i].size(), 0);
   endtask

   // Monitor: consumes one expected entry per completed output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            for (int i = 0; i < 3; i++) begin
               if (ov[i] && out_ready) begin
                  if (q[i].size() == 0) begin
                     chks++;
                     errs++;
                     $display("FAIL unexpected_out_u%0d: got %0d, required no output (cycle %0d)",
                              i, od[i], cyc);
                  end else begin
                     e = q[i].pop_front();
                     chk($sformatf("out_data_u%0d", i), od[i], e.d);
                     if (e.lat)
                        chk($sformatf("latency_u%0d", i), cyc, e.acc + 2);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hold;
      errs = 0;
      chks = 0;
      lat_mode  = 1'b0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) tick();
      chk("in_ready_in_reset", int'(bif0.in_ready), 0);
      chk("out_valid_in_reset", int'(ov[0]), 0);
      chk("out_data_in_reset", od[1], 0);
      chk_sat("reset", 0, 0);
      reset = 1'b0;
      #1;
      chk("in_ready_after_reset", int'(bif0.in_ready), 1);

      // Bias add, rounding around the half LSB, full-rate streaming.
      lat_mode = 1'b1;
      for (int k = 0; k < 5; k++) send(k);
      repeat (4) tick();
      chk_sat("no_sat", 0, 0);
      chk_empty("phaseA");

      // Saturation at both rails, rounding into saturation, ReLU on negatives.
      for (int k = 5; k < 12; k++) send(k);
      repeat (4) tick();
      chk_sat("sat", 4, 1);
      chk_empty("phaseB");

      // Backpressure: two accepts fill the pipe, the third must wait.
      lat_mode  = 1'b0;
      out_ready = 1'b0;
      send(7);
      send(0);
      in_valid = 1'b1;
      in_data  = VIN[4];
      #1;
      chk("bp_in_ready", int'(bif0.in_ready), 0);
      hold = od[0];
      repeat (3) begin
         tick();
         chk("bp_in_ready_hold", int'(bif0.in_ready), 0);
         chk("bp_out_valid_hold", int'(ov[0]), 1);
         chk("bp_out_data_hold", od[0], hold);
      end
      chk("bp_held_value", hold, E0[7]);
      out_ready = 1'b1;
      #1;
      chk("drain_valid0", int'(ov[0]), 1);
      send(4);
      chk("drain_valid1", int'(ov[0]), 1);
      tick();
      chk("drain_valid2", int'(ov[0]), 1);
      tick();
      chk("drain_empty", int'(ov[0]), 0);
      chk_empty("phaseC");
      chk_sat("after_bp", 4, 1);

      // Reset with both stages full: nothing in flight may survive.
      out_ready = 1'b0;
      send(5);
      send(6);
      chk("full_before_reset", int'(ov[0]), 1);
      reset = 1'b1;
      tick();
      chk("in_ready_mid_reset", int'(bif0.in_ready), 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) q[i].delete();
      #1;
      chk("out_valid_after_flush", int'(ov[0]), 0);
      chk("in_ready_after_flush", int'(bif0.in_ready), 1);
      chk_sat("flush", 0, 0);
      out_ready = 1'b1;
      repeat (5) begin
         tick();
         chk("no_stale_out", int'(ov[0]), 0);
      end

      // Recovery after the mid-stream reset.
      lat_mode = 1'b1;
      send(1);
      send(10);
      repeat (4) tick();
      chk_empty("phaseE");
      chk_sat("recover", 0, 0);

      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end
endmodule
